// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle MIPS32 control unit: instruction
// fields, ALU operation codes, PC-source select codes and FSM states.
package cu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // PC source select
  localparam logic [1:0] MUXPC_SEQ    = 2'd0;  // PC+4
  localparam logic [1:0] MUXPC_BRANCH = 2'd1;  // PC+4+(simm<<2)
  localparam logic [1:0] MUXPC_JUMP   = 2'd2;  // dirPC

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } cuState_e;

  typedef enum logic [2:0] {
    CLS_ARITH = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_BEQ   = 3'd3,
    CLS_BNE   = 3'd4,
    CLS_JUMP  = 3'd5,
    CLS_NONE  = 3'd6
  } instrClass_e;

endpackage

// File: rtl/cu_decoder.sv
// Purely combinational instruction decoder: classifies the instruction
// register contents and derives the ALU controls and write-back address.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int DIR_SIZE_INTERNAL = 5,
  parameter int ALUOP_SIZE        = 3
) (
  input  logic [31:0]                  ir,
  output instrClass_e                  instrClass,
  output logic [ALUOP_SIZE-1:0]        aluOp,
  output logic                         aluSrc,
  output logic [DIR_SIZE_INTERNAL-1:0] dirWrite,
  output logic                         legal
);

  // rs and shamt are datapath concerns; the decoder never looks at them.
  logic unusedIr;
  assign unusedIr = ^{ir[25:21], ir[10:6]};

  // Opcode/funct table; anything not listed is reported as not legal.
  always_comb begin
    instrClass = CLS_NONE;
    aluOp      = ALUOP_SIZE'(ALU_ADD);
    aluSrc     = 1'b0;
    legal      = 1'b0;
    dirWrite   = DIR_SIZE_INTERNAL'(ir[20:16]);
    case (ir[31:26])
      OP_RTYPE: begin
        dirWrite   = DIR_SIZE_INTERNAL'(ir[15:11]);
        instrClass = CLS_ARITH;
        legal      = 1'b1;
        case (ir[5:0])
          FN_ADD:  aluOp = ALUOP_SIZE'(ALU_ADD);
          FN_SUB:  aluOp = ALUOP_SIZE'(ALU_SUB);
          FN_AND:  aluOp = ALUOP_SIZE'(ALU_AND);
          FN_OR:   aluOp = ALUOP_SIZE'(ALU_OR);
          FN_SLT:  aluOp = ALUOP_SIZE'(ALU_SLT);
          default: begin
            instrClass = CLS_NONE;
            legal      = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        instrClass = CLS_ARITH;
        aluSrc     = 1'b1;
        legal      = 1'b1;
      end
      OP_ANDI: begin
        instrClass = CLS_ARITH;
        aluOp      = ALUOP_SIZE'(ALU_AND);
        aluSrc     = 1'b1;
        legal      = 1'b1;
      end
      OP_ORI: begin
        instrClass = CLS_ARITH;
        aluOp      = ALUOP_SIZE'(ALU_OR);
        aluSrc     = 1'b1;
        legal      = 1'b1;
      end
      OP_LW: begin
        instrClass = CLS_LOAD;
        aluSrc     = 1'b1;
        legal      = 1'b1;
      end
      OP_SW: begin
        instrClass = CLS_STORE;
        aluSrc     = 1'b1;
        legal      = 1'b1;
      end
      OP_BEQ: begin
        instrClass = CLS_BEQ;
        aluOp      = ALUOP_SIZE'(ALU_SUB);
        legal      = 1'b1;
      end
      OP_BNE: begin
        instrClass = CLS_BNE;
        aluOp      = ALUOP_SIZE'(ALU_SUB);
        legal      = 1'b1;
      end
      OP_J: begin
        instrClass = CLS_JUMP;
        legal      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS32 control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer
// that owns the instruction register and gates PC, register-file and
// memory enables.
//
// Handshakes: instrReq is held high for the whole FETCH state and the
// instruction is taken on the first rising edge where instrValid is also
// high; memRead/memWrite are held high for the whole MEM state and the
// access completes on the first rising edge where memReady is also high.
// instrValid outside FETCH and memReady outside MEM have no effect.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int BUS_SIZE          = 32,
  parameter int DIR_SIZE          = 32,
  parameter int DIR_SIZE_INTERNAL = 5,
  parameter int ALUOP_SIZE        = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_SIZE-1:0]          instr,
  input  logic                         instrValid,
  input  logic                         memReady,
  input  logic                         flagZ,
  input  logic                         flagN,
  input  logic                         flagC,
  output logic                         instrReq,
  output logic                         enPC,
  output logic [1:0]                   muxPC,
  output logic [DIR_SIZE-1:0]          dirPC,
  output logic [ALUOP_SIZE-1:0]        aluOp,
  output logic                         aluSrc,
  output logic                         memRead,
  output logic                         memWrite,
  output logic                         muxWB,
  output logic                         enWrite,
  output logic [DIR_SIZE_INTERNAL-1:0] dirWrite,
  output logic                         illegal,
  output logic [2:0]                   stateDbg
);

  cuState_e                     state;
  cuState_e                     nextState;
  logic [31:0]                  ir;
  instrClass_e                  instrClass;
  logic [ALUOP_SIZE-1:0]        decAluOp;
  logic                         decAluSrc;
  logic [DIR_SIZE_INTERNAL-1:0] decDirWrite;
  logic                         decLegal;

  // Upper instruction bits beyond the MIPS word and the N/C flags are not
  // needed by any instruction this unit sequences.
  logic unusedInputs;
  assign unusedInputs = ^{instr, flagN, flagC};

  assign stateDbg = state;

  cu_decoder #(
    .DIR_SIZE_INTERNAL(DIR_SIZE_INTERNAL),
    .ALUOP_SIZE       (ALUOP_SIZE)
  ) uDecoder (
    .ir        (ir),
    .instrClass(instrClass),
    .aluOp     (decAluOp),
    .aluSrc    (decAluSrc),
    .dirWrite  (decDirWrite),
    .legal     (decLegal)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FETCH;
    else      state <= nextState;
  end

  // Instruction register: loads only on an accepted fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 ir <= '0;
    else if (state == ST_FETCH && instrValid) ir <= instr[31:0];
  end

  // Next-state and Moore outputs; only the branch PC select looks at flagZ.
  always_comb begin
    nextState = state;
    instrReq  = 1'b0;
    enPC      = 1'b0;
    muxPC     = MUXPC_SEQ;
    dirPC     = DIR_SIZE'({ir[25:0], 2'b00});
    aluOp     = '0;
    aluSrc    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    muxWB     = 1'b0;
    enWrite   = 1'b0;
    dirWrite  = '0;
    illegal   = 1'b0;
    case (state)
      ST_FETCH: begin
        instrReq = 1'b1;
        if (instrValid) nextState = ST_DECODE;
      end
      ST_DECODE: begin
        aluOp     = decAluOp;
        aluSrc    = decAluSrc;
        dirWrite  = decDirWrite;
        nextState = decLegal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        aluOp    = decAluOp;
        aluSrc   = decAluSrc;
        dirWrite = decDirWrite;
        case (instrClass)
          CLS_ARITH: nextState = ST_WB;
          CLS_LOAD, CLS_STORE: nextState = ST_MEM;
          CLS_BEQ: begin
            enPC      = 1'b1;
            muxPC     = flagZ ? MUXPC_BRANCH : MUXPC_SEQ;
            nextState = ST_FETCH;
          end
          CLS_BNE: begin
            enPC      = 1'b1;
            muxPC     = flagZ ? MUXPC_SEQ : MUXPC_BRANCH;
            nextState = ST_FETCH;
          end
          CLS_JUMP: begin
            enPC      = 1'b1;
            muxPC     = MUXPC_JUMP;
            nextState = ST_FETCH;
          end
          default: nextState = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        aluOp    = decAluOp;
        aluSrc   = decAluSrc;
        dirWrite = decDirWrite;
        memRead  = (instrClass == CLS_LOAD);
        memWrite = (instrClass == CLS_STORE);
        if (memReady) begin
          if (instrClass == CLS_LOAD) begin
            nextState = ST_WB;
          end else begin
            enPC      = 1'b1;
            nextState = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        aluOp     = decAluOp;
        aluSrc    = decAluSrc;
        dirWrite  = decDirWrite;
        enWrite   = (decDirWrite != '0);
        muxWB     = (instrClass == CLS_LOAD);
        enPC      = 1'b1;
        nextState = ST_FETCH;
      end
      ST_TRAP: begin
        illegal = 1'b1;
      end
      default: nextState = ST_TRAP;
    endcase
    // Reset forces every output low at once, even in the middle of an access.
    if (!rst) begin
      instrReq = 1'b0;
      enPC     = 1'b0;
      muxPC    = MUXPC_SEQ;
      dirPC    = '0;
      aluOp    = '0;
      aluSrc   = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      muxWB    = 1'b0;
      enWrite  = 1'b0;
      dirWrite = '0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
module tb_multicycle_control_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [31:0] instr;
  logic        instrValid, memReady, flagZ, flagN, flagC;
  logic        instrReq, enPC, aluSrc, memRead, memWrite, muxWB, enWrite, illegal;
  logic [1:0]  muxPC;
  logic [31:0] dirPC;
  logic [2:0]  aluOp;
  logic [4:0]  dirWrite;
  logic [2:0]  stateDbg;
  logic [49:0] allOuts;

  assign allOuts = {instrReq, enPC, muxPC, dirPC, aluOp, aluSrc, memRead,
                    memWrite, muxWB, enWrite, dirWrite, illegal};

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .instrValid(instrValid),
    .memReady(memReady), .flagZ(flagZ), .flagN(flagN), .flagC(flagC),
    .instrReq(instrReq), .enPC(enPC), .muxPC(muxPC), .dirPC(dirPC),
    .aluOp(aluOp), .aluSrc(aluSrc), .memRead(memRead), .memWrite(memWrite),
    .muxWB(muxWB), .enWrite(enWrite), .dirWrite(dirWrite), .illegal(illegal),
    .stateDbg(stateDbg)
  );

  // ---------------- scoreboard state ----------------
  int          vecCount  = 0;
  int          missCount = 0;
  logic [7:0]  exp_q[$];

  // Observations of one instruction run
  int          obsLat, obsReqBad, obsRd, obsWr, obsWe;
  logic [1:0]  obsMuxPc;
  logic        obsWeAtPc, obsMwb, obsAluSrc, obsZ;
  logic [4:0]  obsDw;
  logic [31:0] obsDpc;
  logic [2:0]  obsAluOp, obsAluOpAtPc;

  // ---------------- reference model ----------------
  // Expected retirement behaviour of one instruction, straight from the ISA
  // rules: cycle index of the PC strobe, PC select, write-back and ALU controls.
  function automatic void refModel(input logic [31:0] iw, input int waits, input logic z,
                                   output int lat, output logic [1:0] mpc, output logic writes,
                                   output logic [4:0] dest, output logic mwb, output logic [2:0] aop,
                                   output logic asrc, output int rdC, output int wrC, output logic isJ);
    lat = 3; mpc = 2'd0; writes = 1'b0; dest = iw[20:16]; mwb = 1'b0;
    aop = 3'd0; asrc = 1'b0; rdC = 0; wrC = 0; isJ = 1'b0;
    case (iw[31:26])
      6'h00: begin
        writes = 1'b1; dest = iw[15:11];
        case (iw[5:0])
          6'h20: aop = 3'd0;
          6'h22: aop = 3'd1;
          6'h24: aop = 3'd2;
          6'h25: aop = 3'd3;
          default: aop = 3'd4;
        endcase
      end
      6'h08: begin writes = 1'b1; asrc = 1'b1; aop = 3'd0; end
      6'h0C: begin writes = 1'b1; asrc = 1'b1; aop = 3'd2; end
      6'h0D: begin writes = 1'b1; asrc = 1'b1; aop = 3'd3; end
      6'h23: begin writes = 1'b1; asrc = 1'b1; mwb = 1'b1; lat = 4 + waits; rdC = waits + 1; end
      6'h2B: begin asrc = 1'b1; lat = 3 + waits; wrC = waits + 1; end
      6'h04: begin aop = 3'd1; lat = 2; mpc = z ? 2'd1 : 2'd0; end
      6'h05: begin aop = 3'd1; lat = 2; mpc = z ? 2'd0 : 2'd1; end
      default: begin lat = 2; mpc = 2'd2; isJ = 1'b1; end
    endcase
  endfunction

  function automatic logic [31:0] randInstr();
    int          kind;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    kind = $urandom_range(0, 12);
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
    imm = 16'($urandom);
    if ($urandom_range(0, 5) == 0) rt = 5'd0;
    if ($urandom_range(0, 5) == 0) rd = 5'd0;
    case (kind)
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      default: fn = 6'h2A;
    endcase
    case (kind)
      0, 1, 2, 3, 4: return {6'h00, rs, rt, rd, sh, fn};
      5:  return {6'h08, rs, rt, imm};
      6:  return {6'h0C, rs, rt, imm};
      7:  return {6'h0D, rs, rt, imm};
      8:  return {6'h23, rs, rt, imm};
      9:  return {6'h2B, rs, rt, imm};
      10: return {6'h04, rs, rt, imm};
      11: return {6'h05, rs, rt, imm};
      default: return {6'h02, 26'($urandom)};
    endcase
  endfunction

  // ---------------- driver ----------------
  // Offers one instruction after `idle` empty fetch cycles, answers the data
  // memory after `waits` request cycles, injects noise on ignored inputs and
  // records what the unit did until its PC strobe (bounded to 40 cycles).
  task automatic runInstr(input logic [31:0] iw, input int idle, input int waits, input int zMode);
    int reqSeen;
    reqSeen = 0; obsLat = -1; obsReqBad = 0; obsRd = 0; obsWr = 0; obsWe = 0;
    obsMuxPc = 2'd3; obsWeAtPc = 1'b0; obsMwb = 1'b0; obsDw = 5'd0; obsDpc = 32'd0;
    obsAluOp = 3'd7; obsAluSrc = 1'b0; obsAluOpAtPc = 3'd7; obsZ = 1'b0;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      instrValid = 1'b0; instr = $urandom; memReady = 1'($urandom_range(0, 1));
      flagZ = 1'($urandom_range(0, 1));
      #1;
      if (!instrReq || enPC) obsReqBad++;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      instrValid = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      instr      = (k == 0) ? iw : $urandom;
      flagZ      = (zMode < 0) ? 1'($urandom_range(0, 1)) : 1'(zMode);
      flagN      = 1'($urandom_range(0, 1));
      flagC      = 1'($urandom_range(0, 1));
      memReady   = (reqSeen >= waits);
      #1;
      if ((k == 0) != instrReq) obsReqBad++;
      if (memRead)  begin obsRd++; reqSeen++; end
      if (memWrite) begin obsWr++; reqSeen++; end
      if (enWrite)  obsWe++;
      if (k == 2) begin obsAluOp = aluOp; obsAluSrc = aluSrc; end
      if (enPC) begin
        obsLat = k; obsMuxPc = muxPC; obsWeAtPc = enWrite; obsMwb = muxWB;
        obsDw = dirWrite; obsDpc = dirPC; obsAluOpAtPc = aluOp; obsZ = flagZ;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; instr = 32'hFFFF_FFFF; instrValid = 1'b1; memReady = 1'b1;
    flagZ = 1'b1; flagN = 1'b0; flagC = 1'b0;
    #1 rst = 1'b0;
    #2;
    vecCount++;
    if (allOuts !== 50'd0) begin missCount++; $display("FAIL reset_immediate: got %h expected 0", allOuts); end
    @(negedge clk); @(negedge clk);
    vecCount++;
    if (allOuts !== 50'd0) begin missCount++; $display("FAIL reset_held: got %h expected 0", allOuts); end
    rst = 1'b1; instrValid = 1'b0;
    #1;
    vecCount++;
    if ({instrReq, enPC, illegal} !== 3'b100) begin
      missCount++; $display("FAIL reset_release_fetch: got %b expected 100", {instrReq, enPC, illegal});
    end
  endtask

  task automatic test_add();
    runInstr(32'h00221820, 0, 0, -1);
    vecCount++; if (obsLat !== 3) begin missCount++; $display("FAIL add_latency: got %0d expected 3", obsLat); end
    vecCount++;
    if ({obsWeAtPc, obsDw, obsAluOpAtPc, obsMuxPc} !== {1'b1, 5'd3, 3'd0, 2'd0}) begin
      missCount++; $display("FAIL add_wb: got we=%b dw=%0d aop=%0d mux=%0d expected 1 3 0 0",
                            obsWeAtPc, obsDw, obsAluOpAtPc, obsMuxPc);
    end
  endtask

  task automatic test_lw_waits();
    runInstr(32'h8C250004, 0, 3, -1);
    vecCount++; if (obsRd !== 4) begin missCount++; $display("FAIL lw_memread_cycles: got %0d expected 4", obsRd); end
    vecCount++; if (obsLat !== 7) begin missCount++; $display("FAIL lw_latency: got %0d expected 7", obsLat); end
    vecCount++;
    if ({obsWeAtPc, obsMwb, obsDw, obsAluSrc} !== {1'b1, 1'b1, 5'd5, 1'b1}) begin
      missCount++; $display("FAIL lw_wb: got we=%b mwb=%b dw=%0d asrc=%b expected 1 1 5 1",
                            obsWeAtPc, obsMwb, obsDw, obsAluSrc);
    end
  endtask

  task automatic test_branches();
    logic [31:0] words [2];
    words[0] = 32'h10220003;  // BEQ
    words[1] = 32'h14220003;  // BNE
    for (int b = 0; b < 2; b++) begin
      for (int z = 0; z < 2; z++) begin
        logic [1:0] expMux;
        expMux = ((b == 0) == (z == 1)) ? 2'd1 : 2'd0;
        runInstr(words[b], $urandom_range(0, 2), 0, z);
        vecCount++;
        if ({obsLat == 2, obsMuxPc, obsAluOp, obsWe == 0} !== {1'b1, expMux, 3'd1, 1'b1}) begin
          missCount++; $display("FAIL branch[%0d z=%0d]: got lat=%0d mux=%0d aop=%0d we=%0d expected lat=2 mux=%0d aop=1 we=0",
                                b, z, obsLat, obsMuxPc, obsAluOp, obsWe, expMux);
        end
      end
    end
  endtask

  task automatic test_jump_and_r0();
    runInstr(32'h08000010, 0, 0, -1);
    vecCount++;
    if ({obsLat == 2, obsMuxPc, obsDpc} !== {1'b1, 2'd2, 32'h0000_0040}) begin
      missCount++; $display("FAIL jump: got lat=%0d mux=%0d dirPC=%h expected lat=2 mux=2 dirPC=00000040",
                            obsLat, obsMuxPc, obsDpc);
    end
    runInstr(32'h20000005, 1, 0, -1);
    vecCount++;
    if ({obsLat == 3, obsWe} !== {1'b1, 32'd0}) begin
      missCount++; $display("FAIL addi_r0: got lat=%0d enWrite cycles=%0d expected lat=3 0", obsLat, obsWe);
    end
  endtask

  task automatic test_reset_mid_mem();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      instrValid = (k == 0); instr = (k == 0) ? 32'hAD400000 : $urandom; memReady = 1'b0;
    end
    #1;
    vecCount++; if (memWrite !== 1'b1) begin missCount++; $display("FAIL sw_in_mem: got %b expected 1", memWrite); end
    #1 rst = 1'b0;
    #1;
    vecCount++; if (allOuts !== 50'd0) begin missCount++; $display("FAIL reset_mid_mem: got %h expected 0", allOuts); end
    @(negedge clk);
    rst = 1'b1; instrValid = 1'b0;
    #1;
    vecCount++;
    if ({instrReq, memWrite, enPC} !== 3'b100) begin
      missCount++; $display("FAIL reset_mid_mem_fetch: got %b expected 100", {instrReq, memWrite, enPC});
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [2];
    words[0] = 32'hFC000000;  // opcode 111111
    words[1] = 32'h00221801;  // R-type with unknown funct
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        logic [5:0] expV;
        @(negedge clk);
        instrValid = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        instr      = (k == 0) ? words[w] : $urandom;
        memReady   = 1'($urandom_range(0, 1));
        flagZ      = 1'($urandom_range(0, 1));
        #1;
        expV = (k == 0) ? 6'b010000 : (k == 1) ? 6'b000000 : 6'b100000;
        vecCount++;
        if ({illegal, instrReq, enPC, enWrite, memRead, memWrite} !== expV) begin
          missCount++; $display("FAIL illegal[%0d] cycle %0d: got %b expected %b", w, k,
                                {illegal, instrReq, enPC, enWrite, memRead, memWrite}, expV);
        end
      end
      #1 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; instrValid = 1'b0;
      #1;
      vecCount++;
      if ({illegal, instrReq} !== 2'b01) begin
        missCount++; $display("FAIL illegal_cleared[%0d]: got %b expected 01", w, {illegal, instrReq});
      end
    end
  endtask

  task automatic test_random(input int n, input int maxIdle, input int maxWait);
    logic [31:0] iw;
    int          waits, lat, rdC, wrC;
    logic [7:0]  expLat;
    logic [1:0]  mpc;
    logic        writes, mwb, asrc, isJ;
    logic [4:0]  dest;
    logic [2:0]  aop;
    for (int i = 0; i < n; i++) begin
      iw    = randInstr();
      waits = $urandom_range(0, maxWait);
      refModel(iw, waits, 1'b0, lat, mpc, writes, dest, mwb, aop, asrc, rdC, wrC, isJ);
      exp_q.push_back(8'(lat));
      runInstr(iw, $urandom_range(0, maxIdle), waits, -1);
      expLat = exp_q.pop_front();
      refModel(iw, waits, obsZ, lat, mpc, writes, dest, mwb, aop, asrc, rdC, wrC, isJ);
      vecCount++;
      if (obsLat !== int'(expLat)) begin
        missCount++; $display("FAIL rand_latency[%0d] %h: got %0d expected %0d", i, iw, obsLat, expLat);
      end
      vecCount++;
      if ({obsReqBad, obsRd, obsWr} !== {32'd0, rdC, wrC}) begin
        missCount++; $display("FAIL rand_handshake[%0d] %h: got reqBad=%0d rd=%0d wr=%0d expected 0 %0d %0d",
                              i, iw, obsReqBad, obsRd, obsWr, rdC, wrC);
      end
      vecCount++;
      if ({obsMuxPc, obsWeAtPc, obsWe} !== {mpc, writes && dest != 0, (writes && dest != 0) ? 32'd1 : 32'd0}) begin
        missCount++; $display("FAIL rand_retire[%0d] %h: got mux=%0d we=%b weCycles=%0d expected mux=%0d we=%b",
                              i, iw, obsMuxPc, obsWeAtPc, obsWe, mpc, writes && dest != 0);
      end
      if (writes) begin
        vecCount++;
        if ({obsDw, obsMwb} !== {dest, mwb}) begin
          missCount++; $display("FAIL rand_wb[%0d] %h: got dw=%0d mwb=%b expected dw=%0d mwb=%b",
                                i, iw, obsDw, obsMwb, dest, mwb);
        end
      end
      if (isJ) begin
        vecCount++;
        if (obsDpc !== {4'b0, iw[25:0], 2'b00}) begin
          missCount++; $display("FAIL rand_dirpc[%0d] %h: got %h expected %h", i, iw, obsDpc, {4'b0, iw[25:0], 2'b00});
        end
      end else begin
        vecCount++;
        if ({obsAluOp, obsAluSrc} !== {aop, asrc}) begin
          missCount++; $display("FAIL rand_alu[%0d] %h: got aop=%0d asrc=%b expected aop=%0d asrc=%b",
                                i, iw, obsAluOp, obsAluSrc, aop, asrc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_random(40, 0, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_lw_waits();
    test_branches();
    test_jump_and_r0();
    test_reset_mid_mem();
    test_illegal();
    test_random(150, 2, 3);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
